multicycle_control: RTL and testbench

Multi-cycle control unit that replaces the purely combinational decoder. It accepts one instruction at a time over a valid/ready handshake and decodes R-type, I-type ALU, LW and SW. It then sequences the datapath through DECODE, EXEC, MEM and WB states, emitting ALU, memory and register-write controls. MUL holds EXEC for a parametrised number of cycles, and unsupported encodings are flagged.

---
 rtl/multicycle_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32 control unit (DECODE/EXEC/MEM/WB sequencer)
module multicycle_control #(
    parameter int MUL_LATENCY = 4,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    input  logic                  mem_done,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_src_imm,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  regwrite_control,
    output logic [4:0]            rd_addr,
    output logic                  illegal,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] alu;
        logic       imm;
        logic       load;
        logic       store;
        logic       mul;
    } dec_t;

    // MUL stays in EXEC while the counter is non-zero, so loading LATENCY-1 gives LATENCY cycles
    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

    function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        dec_t d;
        d = '0;
        case (op)
            7'h33: begin
                if (f7 == 7'h00) begin
                    d.legal = (f3 != 3'd3);
                    case (f3)
                        3'd0: d.alu = 4'b0010;
                        3'd1: d.alu = 4'b0011;
                        3'd2: begin
                            d.alu = 4'b0110;
                            d.mul = 1'b1;
                        end
                        3'd4: d.alu = 4'b0111;
                        3'd5: d.alu = 4'b0101;
                        3'd6: d.alu = 4'b0001;
                        3'd7: d.alu = 4'b0000;
                        default: d.alu = 4'b0000;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    d.legal = 1'b1;
                    d.alu   = 4'b0100;
                end
            end
            7'h13: begin
                d.imm = 1'b1;
                case (f3)
                    3'd0: begin d.legal = 1'b1; d.alu = 4'b0010; end
                    3'd4: begin d.legal = 1'b1; d.alu = 4'b0111; end
                    3'd6: begin d.legal = 1'b1; d.alu = 4'b0001; end
                    3'd7: begin d.legal = 1'b1; d.alu = 4'b0000; end
                    3'd1: begin d.legal = (f7 == 7'h00); d.alu = 4'b0011; end
                    3'd5: begin d.legal = (f7 == 7'h00); d.alu = 4'b0101; end
                    default: d.legal = 1'b0;
                endcase
            end
            7'h03: begin
                if (f3 == 3'd2) begin
                    d.legal = 1'b1;
                    d.alu   = 4'b0010;
                    d.imm   = 1'b1;
                    d.load  = 1'b1;
                end
            end
            7'h23: begin
                if (f3 == 3'd2) begin
                    d.legal = 1'b1;
                    d.alu   = 4'b0010;
                    d.imm   = 1'b1;
                    d.store = 1'b1;
                end
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t                  state_q, state_d;
    logic [31:0]             instr_word_q, instr_word_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    is_load_q, is_load_d;
    logic                    is_store_q, is_store_d;
    logic                    instr_ready_q, instr_ready_d;
    logic                    busy_q, busy_d;
    logic                    illegal_q, illegal_d;
    logic [ALU_CTRL_W-1:0]   alu_control_q, alu_control_d;
    logic                    alu_src_imm_q, alu_src_imm_d;
    logic                    mem_to_reg_q, mem_to_reg_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic                    regwrite_q, regwrite_d;
    logic [4:0]              rd_addr_q, rd_addr_d;

    dec_t dec_in;
    dec_t dec_q;
    logic unused_ok;

    assign dec_in    = decode(instr[6:0], instr[14:12], instr[31:25]);
    assign dec_q     = decode(instr_word_q[6:0], instr_word_q[14:12], instr_word_q[31:25]);
    assign unused_ok = ^{instr_word_q[24:15], dec_in.alu, dec_in.imm, dec_in.load, dec_in.store, dec_in.mul};

    // Next-state and next-output logic; every output flop is loaded from its value for the next state
    always_comb begin
        state_d       = state_q;
        instr_word_d  = instr_word_q;
        cnt_d         = cnt_q;
        is_load_d     = is_load_q;
        is_store_d    = is_store_q;
        alu_control_d = alu_control_q;
        alu_src_imm_d = alu_src_imm_q;
        mem_to_reg_d  = mem_to_reg_q;
        rd_addr_d     = rd_addr_q;
        illegal_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_word_d = instr;
                    illegal_d    = !dec_in.legal;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_q.legal) begin
                    state_d = S_IDLE;
                end else begin
                    alu_control_d = ALU_CTRL_W'(dec_q.alu);
                    alu_src_imm_d = dec_q.imm;
                    mem_to_reg_d  = dec_q.load;
                    rd_addr_d     = instr_word_q[11:7];
                    is_load_d     = dec_q.load;
                    is_store_d    = dec_q.store;
                    cnt_d         = dec_q.mul ? CNT_INIT : 4'd0;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (is_load_q || is_store_q) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    state_d = is_load_q ? S_WB : S_IDLE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Latched controls only live for the duration of one instruction
        if (state_d == S_IDLE) begin
            alu_control_d = '0;
            alu_src_imm_d = 1'b0;
            mem_to_reg_d  = 1'b0;
            rd_addr_d     = 5'd0;
            is_load_d     = 1'b0;
            is_store_d    = 1'b0;
        end

        instr_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        mem_read_d    = (state_d == S_MEM) && is_load_d;
        mem_write_d   = (state_d == S_MEM) && is_store_d;
        regwrite_d    = (state_d == S_WB) && (rd_addr_d != 5'd0);
    end

    // State and output registers; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            instr_word_q  <= '0;
            cnt_q         <= '0;
            is_load_q     <= 1'b0;
            is_store_q    <= 1'b0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            illegal_q     <= 1'b0;
            alu_control_q <= '0;
            alu_src_imm_q <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            regwrite_q    <= 1'b0;
            rd_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            instr_word_q  <= instr_word_d;
            cnt_q         <= cnt_d;
            is_load_q     <= is_load_d;
            is_store_q    <= is_store_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            illegal_q     <= illegal_d;
            alu_control_q <= alu_control_d;
            alu_src_imm_q <= alu_src_imm_d;
            mem_to_reg_q  <= mem_to_reg_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            regwrite_q    <= regwrite_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign instr_ready      = instr_ready_q;
    assign busy             = busy_q;
    assign illegal          = illegal_q;
    assign alu_control      = alu_control_q;
    assign alu_src_imm      = alu_src_imm_q;
    assign mem_to_reg       = mem_to_reg_q;
    assign mem_read         = mem_read_q;
    assign mem_write        = mem_write_q;
    assign regwrite_control = regwrite_q;
    assign rd_addr          = rd_addr_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int L  = 4;
    localparam int AW = 4;

    localparam int K_R   = 0;
    localparam int K_MUL = 1;
    localparam int K_I   = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;

    localparam logic [31:0] W_ADD  = 32'h002081B3;
    localparam logic [31:0] W_SUB  = 32'h402081B3;
    localparam logic [31:0] W_MUL  = 32'h0020A1B3;
    localparam logic [31:0] W_LW   = 32'h0000A283;
    localparam logic [31:0] W_SW   = 32'h0050A023;
    localparam logic [31:0] W_ILL  = 32'hFFFFFFFF;
    localparam logic [31:0] W_ADDI = 32'h00100013;
    localparam logic [31:0] W_SLLI = 32'h40001013;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic          mem_done;
    logic [AW-1:0] alu_control;
    logic          alu_src_imm;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          regwrite_control;
    logic [4:0]    rd_addr;
    logic          illegal;
    logic          busy;

    multicycle_control #(.MUL_LATENCY(L), .ALU_CTRL_W(AW)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .mem_done(mem_done), .alu_control(alu_control), .alu_src_imm(alu_src_imm),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .regwrite_control(regwrite_control), .rd_addr(rd_addr), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Output vector: ready[16] busy[15] illegal[14] alu[13:10] imm[9] mr[8] mw[7] m2r[6] rw[5] rd[4:0]
    logic [16:0] obs [0:63];

    logic [31:0] pmask  [16];
    logic [31:0] pmatch [16];
    logic [3:0]  palu   [16];
    int          pkind  [16];

    function automatic logic [16:0] mk(input logic r, input logic b, input logic i, input logic [3:0] a,
                                       input logic imm, input logic mr, input logic mw, input logic m2r,
                                       input logic rw, input logic [4:0] rd);
        return {r, b, i, a, imm, mr, mw, m2r, rw, rd};
    endfunction

    function automatic logic [16:0] pack_outs();
        return {instr_ready, busy, illegal, alu_control, alu_src_imm, mem_read, mem_write,
                mem_to_reg, regwrite_control, rd_addr};
    endfunction

    task automatic set_pat(input int i, input logic [31:0] m, input logic [31:0] v,
                           input logic [3:0] a, input int k);
        pmask[i] = m; pmatch[i] = v; palu[i] = a; pkind[i] = k;
    endtask

    task automatic init_table();
        set_pat(0,  32'hFE00707F, 32'h00000033, 4'b0010, K_R);
        set_pat(1,  32'hFE00707F, 32'h00001033, 4'b0011, K_R);
        set_pat(2,  32'hFE00707F, 32'h00002033, 4'b0110, K_MUL);
        set_pat(3,  32'hFE00707F, 32'h00004033, 4'b0111, K_R);
        set_pat(4,  32'hFE00707F, 32'h00005033, 4'b0101, K_R);
        set_pat(5,  32'hFE00707F, 32'h00006033, 4'b0001, K_R);
        set_pat(6,  32'hFE00707F, 32'h00007033, 4'b0000, K_R);
        set_pat(7,  32'hFE00707F, 32'h40000033, 4'b0100, K_R);
        set_pat(8,  32'h0000707F, 32'h00000013, 4'b0010, K_I);
        set_pat(9,  32'h0000707F, 32'h00004013, 4'b0111, K_I);
        set_pat(10, 32'h0000707F, 32'h00006013, 4'b0001, K_I);
        set_pat(11, 32'h0000707F, 32'h00007013, 4'b0000, K_I);
        set_pat(12, 32'hFE00707F, 32'h00001013, 4'b0011, K_I);
        set_pat(13, 32'hFE00707F, 32'h00005013, 4'b0101, K_I);
        set_pat(14, 32'h0000707F, 32'h00002003, 4'b0010, K_LW);
        set_pat(15, 32'h0000707F, 32'h00002023, 4'b0010, K_SW);
    endtask

    function automatic int ref_idx(input logic [31:0] w);
        for (int i = 0; i < 16; i++)
            if ((w & pmask[i]) == pmatch[i]) return i;
        return -1;
    endfunction

    function automatic int exec_len(input int kind);
        return (kind == K_MUL) ? L : 1;
    endfunction

    // Cycles after accept up to and including the first idle cycle
    function automatic int trace_len(input logic [31:0] w, input int wt);
        int idx, n;
        idx = ref_idx(w);
        if (idx < 0) return 2;
        n = 1 + exec_len(pkind[idx]);
        if (pkind[idx] == K_LW || pkind[idx] == K_SW) n += wt + 1;
        if (pkind[idx] != K_SW) n += 1;
        return n + 1;
    endfunction

    function automatic logic [16:0] model_out(input logic [31:0] w, input int wt, input int k);
        int idx, kind, p;
        logic [3:0] a;
        logic imm, m2r;
        logic [4:0] rd;
        logic [16:0] idle_v;
        idle_v = mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd0);
        idx = ref_idx(w);
        if (idx < 0) return (k == 1) ? mk(0, 1, 1, 4'd0, 0, 0, 0, 0, 0, 5'd0) : idle_v;
        if (k == 1) return mk(0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 5'd0);
        kind = pkind[idx];
        a    = palu[idx];
        imm  = (kind == K_I || kind == K_LW || kind == K_SW);
        m2r  = (kind == K_LW);
        rd   = w[11:7];
        if (k <= 1 + exec_len(kind)) return mk(0, 1, 0, a, imm, 0, 0, m2r, 0, rd);
        p = 2 + exec_len(kind);
        if (kind == K_LW || kind == K_SW) begin
            if (k <= p + wt) return mk(0, 1, 0, a, imm, kind == K_LW, kind == K_SW, m2r, 0, rd);
            p = p + wt + 1;
        end
        if (kind != K_SW && k == p) return mk(0, 1, 0, a, imm, 0, 0, m2r, rd != 5'd0, rd);
        return idle_v;
    endfunction

    // Drives one instruction starting in the current (idle) cycle and records outputs for cycles 1..n
    task automatic run_instr(input logic [31:0] w, input int wt, output int n);
        int idx, lo, hi;
        logic [16:0] e;
        idx = ref_idx(w);
        lo = -1; hi = -1;
        if (idx >= 0 && (pkind[idx] == K_LW || pkind[idx] == K_SW)) begin
            lo = 2 + exec_len(pkind[idx]);
            hi = lo + wt;
        end
        n = trace_len(w, wt);
        instr_valid = 1'b1;
        instr       = w;
        mem_done    = 1'($urandom);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            obs[k] = pack_outs();
            e = model_out(w, wt, k);
            instr_valid = e[16] ? 1'b0 : 1'($urandom);
            instr       = $urandom;
            mem_done    = (k >= lo && k <= hi) ? (k == hi) : 1'($urandom);
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b1; instr = W_ADD; mem_done = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (pack_outs() !== mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd0)) begin
            fails++; $display("FAIL reset_state got %h exp %h", pack_outs(), mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd0));
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || instr_ready !== 1'b1) begin
            fails++; $display("FAIL reset_beats_valid busy=%b ready=%b exp busy=0 ready=1", busy, instr_ready);
        end
        reset = 1'b0; instr_valid = 1'b0; mem_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int n;
        logic [16:0] e;
        run_instr(W_ADD, 0, n);
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_ADD, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL add_trace k=%0d got %h exp %h", k, obs[k], e); end
        end
        tests++;
        if (obs[2][13:10] !== 4'b0010) begin fails++; $display("FAIL add_alu got %b exp 0010", obs[2][13:10]); end
        tests++;
        if (obs[3][5] !== 1'b1 || obs[3][4:0] !== 5'd3) begin
            fails++; $display("FAIL add_wb_c3 rw=%b rd=%0d exp rw=1 rd=3", obs[3][5], obs[3][4:0]);
        end
        tests++;
        if (obs[4][16] !== 1'b1) begin fails++; $display("FAIL add_ready_c4 got %b exp 1", obs[4][16]); end
    endtask

    task automatic test_sub_mul();
        int n;
        logic [16:0] e;
        run_instr(W_SUB, 0, n);
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_SUB, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL sub_trace k=%0d got %h exp %h", k, obs[k], e); end
        end
        tests++;
        if (obs[2][13:10] !== 4'b0100) begin fails++; $display("FAIL sub_alu got %b exp 0100", obs[2][13:10]); end
        run_instr(W_MUL, 0, n);
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_MUL, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL mul_trace k=%0d got %h exp %h", k, obs[k], e); end
        end
        for (int k = 2; k <= 5; k++) begin
            tests++;
            if (obs[k][13:10] !== 4'b0110 || obs[k][5] !== 1'b0) begin
                fails++; $display("FAIL mul_exec k=%0d alu=%b rw=%b exp alu=0110 rw=0", k, obs[k][13:10], obs[k][5]);
            end
        end
        tests++;
        if (obs[6][5] !== 1'b1) begin fails++; $display("FAIL mul_wb_c6 got %b exp 1", obs[6][5]); end
    endtask

    task automatic test_lw();
        int n, cnt;
        logic [16:0] e;
        run_instr(W_LW, 3, n);
        cnt = 0;
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_LW, 3, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL lw_trace k=%0d got %h exp %h", k, obs[k], e); end
            cnt += int'(obs[k][8]);
        end
        tests++;
        if (cnt != 4) begin fails++; $display("FAIL lw_read_cycles got %0d exp 4", cnt); end
        tests++;
        if (obs[7][6] !== 1'b1 || obs[7][5] !== 1'b1 || obs[7][4:0] !== 5'd5) begin
            fails++; $display("FAIL lw_wb m2r=%b rw=%b rd=%0d exp 1 1 5", obs[7][6], obs[7][5], obs[7][4:0]);
        end
    endtask

    task automatic test_sw_illegal();
        int n, cw, crw;
        logic [16:0] e;
        run_instr(W_SW, 0, n);
        cw = 0; crw = 0;
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_SW, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL sw_trace k=%0d got %h exp %h", k, obs[k], e); end
            cw += int'(obs[k][7]); crw += int'(obs[k][5]);
        end
        tests++;
        if (cw != 1 || crw != 0) begin fails++; $display("FAIL sw_strobes write=%0d rw=%0d exp 1 0", cw, crw); end
        run_instr(W_ILL, 0, n);
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_ILL, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL ill_trace k=%0d got %h exp %h", k, obs[k], e); end
        end
        tests++;
        if (obs[1][14] !== 1'b1 || obs[2][14] !== 1'b0) begin
            fails++; $display("FAIL ill_pulse c1=%b c2=%b exp 1 0", obs[1][14], obs[2][14]);
        end
    endtask

    task automatic test_addi_slli();
        int n;
        logic [16:0] e;
        run_instr(W_ADDI, 0, n);
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_ADDI, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL addi_trace k=%0d got %h exp %h", k, obs[k], e); end
        end
        tests++;
        if (obs[3][5] !== 1'b0 || obs[2][9] !== 1'b1) begin
            fails++; $display("FAIL addi_x0 rw=%b imm=%b exp rw=0 imm=1", obs[3][5], obs[2][9]);
        end
        run_instr(W_SLLI, 0, n);
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_SLLI, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL slli_trace k=%0d got %h exp %h", k, obs[k], e); end
        end
        tests++;
        if (obs[1][14] !== 1'b1) begin fails++; $display("FAIL slli_illegal got %b exp 1", obs[1][14]); end
    endtask

    task automatic test_reset_mid_mul();
        int n, crw;
        logic [16:0] e;
        instr_valid = 1'b1; instr = W_MUL; mem_done = 1'b0;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1 || alu_control !== 4'b0110) begin
            fails++; $display("FAIL mid_mul_pre busy=%b alu=%b exp 1 0110", busy, alu_control);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++;
        if (pack_outs() !== mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd0)) begin
            fails++; $display("FAIL mid_mul_reset got %h exp %h", pack_outs(), mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd0));
        end
        crw = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            crw += int'(regwrite_control) + int'(busy);
        end
        tests++;
        if (crw != 0) begin fails++; $display("FAIL mid_mul_quiet got %0d exp 0", crw); end
        run_instr(W_ADD, 0, n);
        for (int k = 1; k <= n; k++) begin
            e = model_out(W_ADD, 0, k); tests++;
            if (obs[k] !== e) begin fails++; $display("FAIL post_reset_add k=%0d got %h exp %h", k, obs[k], e); end
        end
    endtask

    task automatic test_random();
        int n, wt, idx;
        logic [31:0] w;
        logic [16:0] e;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
            end else begin
                idx = $urandom_range(0, 15);
                w = ($urandom & ~pmask[idx]) | pmatch[idx];
            end
            wt = $urandom_range(0, 3);
            run_instr(w, wt, n);
            for (int k = 1; k <= n; k++) begin
                e = model_out(w, wt, k); tests++;
                if (obs[k] !== e) begin
                    fails++; $display("FAIL rand_trace w=%h wt=%0d k=%0d got %h exp %h", w, wt, k, obs[k], e);
                end
            end
        end
    endtask

    initial begin
        init_table();
        reset = 1'b1; instr_valid = 1'b0; instr = '0; mem_done = 1'b0;
        test_reset();
        test_add();
        test_sub_mul();
        test_lw();
        test_sw_illegal();
        test_addi_slli();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
